// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU operation sequencer.
//   state_t        : sequencer state encoding (IDLE..DONE, ERR)
//   field_opcode   : opcode field from the instruction MSBs
//   field_p1/p2    : register-index fields that follow the opcode
//   mask_hit       : tests whether an opcode's bit is set in a class mask
package alu_seq_pkg;

    // Widest instruction / opcode space the helpers accept.
    localparam int MAX_W = 64;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_DRV,
        ST_A_LAT,
        ST_GAP,
        ST_B_DRV,
        ST_B_LAT,
        ST_EXEC,
        ST_WB_DRV,
        ST_WB,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [31:0] extract_field(input logic [MAX_W-1:0] instr,
                                                  input int lsb, input int width);
        logic [MAX_W-1:0] shifted;
        shifted = instr >> lsb;
        return 32'(shifted & ((64'd1 << width) - 64'd1));
    endfunction

    function automatic logic [31:0] field_opcode(input logic [MAX_W-1:0] instr,
                                                 input int instr_w, input int opc_w);
        return extract_field(instr, instr_w - opc_w, opc_w);
    endfunction

    function automatic logic [31:0] field_p1(input logic [MAX_W-1:0] instr, input int instr_w,
                                             input int opc_w, input int reg_idx_w);
        return extract_field(instr, instr_w - opc_w - reg_idx_w, reg_idx_w);
    endfunction

    function automatic logic [31:0] field_p2(input logic [MAX_W-1:0] instr, input int instr_w,
                                             input int opc_w, input int reg_idx_w);
        return extract_field(instr, instr_w - opc_w - 2 * reg_idx_w, reg_idx_w);
    endfunction

    function automatic logic mask_hit(input logic [MAX_W-1:0] mask, input logic [31:0] opc);
        return (opc < 32'(MAX_W)) ? mask[opc[5:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot bus-enable decoder.
//   idx    : register index
//   valid  : idx addresses an existing register (idx < NUM_REGS)
//   onehot : index i sets bit NUM_REGS-1-i (index 0 is the MSB); zero when invalid
module reg_sel_decoder #(
    parameter int REG_IDX_W = 6,
    parameter int NUM_REGS  = 6
) (
    input  logic [REG_IDX_W-1:0] idx,
    output logic                 valid,
    output logic [NUM_REGS-1:0]  onehot
);

    assign valid = (32'(idx) < NUM_REGS);

    always_comb begin
        // NOTE: default assignment first so no path leaves onehot unassigned (no latch).
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == i) onehot[NUM_REGS-1-i] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for ALU-class instructions.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : instruction valid, sampled only in IDLE
//   instruction     : {opcode, p1, p2, pad}; p1 = dest/src A, p2 = src B
//   busy            : high whenever the sequencer is not IDLE
//   done / illegal  : one-cycle completion / bad-register-index pulses
//   pc_inc          : one-cycle PC increment, once per accepted op
//   rx_out / rx_in  : one-hot register-to-bus / bus-to-register enables
//   alu_in0/alu_in1 : latch bus into ALU operand 0 / 1
//   alu_out_latch   : latch ALU result; alu_out_en drives it onto the bus
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int                       INSTR_W    = 16,
    parameter int                       OPC_W      = 4,
    parameter int                       REG_IDX_W  = 6,
    parameter int                       NUM_REGS   = 6,
    parameter logic [(1<<OPC_W)-1:0]    ALU_MASK   = 16'hFE00,
    parameter logic [(1<<OPC_W)-1:0]    UNARY_MASK = 16'h8000,
    parameter logic [(1<<OPC_W)-1:0]    NOWB_MASK  = 16'h0000,
    parameter int                       WAIT_CYC   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                pc_inc,
    output logic [NUM_REGS-1:0] rx_out,
    output logic [NUM_REGS-1:0] rx_in,
    output logic                alu_in0,
    output logic                alu_in1,
    output logic                alu_out_latch,
    output logic                alu_out_en
);

    localparam int              CNT_W    = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    // Decode of the live instruction, used only for the accept decision.
    logic [OPC_W-1:0]     opc_live;
    logic [REG_IDX_W-1:0] p1_live, p2_live;
    logic                 p1_ok, p2_ok;
    logic [NUM_REGS-1:0]  p1_oh_live, p2_oh_live;
    logic                 alu_live, unary_live, nowb_live, legal_live;

    assign opc_live   = OPC_W'(field_opcode(64'(instruction), INSTR_W, OPC_W));
    assign p1_live    = REG_IDX_W'(field_p1(64'(instruction), INSTR_W, OPC_W, REG_IDX_W));
    assign p2_live    = REG_IDX_W'(field_p2(64'(instruction), INSTR_W, OPC_W, REG_IDX_W));
    assign alu_live   = mask_hit(64'(ALU_MASK), 32'(opc_live));
    assign unary_live = mask_hit(64'(UNARY_MASK), 32'(opc_live));
    assign nowb_live  = mask_hit(64'(NOWB_MASK), 32'(opc_live));
    // Source B is only checked when the opcode actually reads it.
    assign legal_live = p1_ok && (unary_live || p2_ok);

    reg_sel_decoder #(.REG_IDX_W(REG_IDX_W), .NUM_REGS(NUM_REGS)) u_dec_p1 (
        .idx(p1_live), .valid(p1_ok), .onehot(p1_oh_live)
    );

    reg_sel_decoder #(.REG_IDX_W(REG_IDX_W), .NUM_REGS(NUM_REGS)) u_dec_p2 (
        .idx(p2_live), .valid(p2_ok), .onehot(p2_oh_live)
    );

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_REGS-1:0]  p1_oh, p2_oh;
    logic                 unary_q, nowb_q;

    // State register and drive-cycle counter. The counter reloads on entry
    // to either DRV state and counts down to zero while it sits there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state && (next_state == ST_A_DRV || next_state == ST_B_DRV))
                cnt <= CNT_LOAD;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // Instruction capture. Refreshed every IDLE cycle, so it holds the
    // accepted instruction for the whole operation.
    always_ff @(posedge clk) begin
        // NOTE: pure data path, no reset: outputs are gated by state, which is reset.
        if (state == ST_IDLE) begin
            p1_oh   <= p1_oh_live;
            p2_oh   <= p2_oh_live;
            unary_q <= unary_live;
            nowb_q  <= nowb_live;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (start && alu_live) next_state = legal_live ? ST_A_DRV : ST_ERR;
            ST_A_DRV:  if (cnt == '0) next_state = ST_A_LAT;
            ST_A_LAT:  next_state = unary_q ? ST_EXEC : ST_GAP;
            ST_GAP:    next_state = ST_B_DRV;
            ST_B_DRV:  if (cnt == '0) next_state = ST_B_LAT;
            ST_B_LAT:  next_state = ST_EXEC;
            ST_EXEC:   next_state = nowb_q ? ST_DONE : ST_WB_DRV;
            ST_WB_DRV: next_state = ST_WB;
            ST_WB:     next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            ST_ERR:    next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        busy          = (state != ST_IDLE);
        done          = 1'b0;
        illegal       = 1'b0;
        pc_inc        = 1'b0;
        rx_out        = '0;
        rx_in         = '0;
        alu_in0       = 1'b0;
        alu_in1       = 1'b0;
        alu_out_latch = 1'b0;
        alu_out_en    = 1'b0;
        unique case (state)
            ST_A_DRV: begin
                rx_out = p1_oh;
                // Counter still holds its reload value only on the first cycle.
                pc_inc = (cnt == CNT_LOAD);
            end
            ST_A_LAT: begin
                rx_out  = p1_oh;
                alu_in0 = 1'b1;
            end
            ST_B_DRV: rx_out = p2_oh;
            ST_B_LAT: begin
                rx_out  = p2_oh;
                alu_in1 = 1'b1;
            end
            ST_EXEC:   alu_out_latch = 1'b1;
            ST_WB_DRV: alu_out_en = 1'b1;
            ST_WB: begin
                alu_out_en = 1'b1;
                rx_in      = p1_oh;
            end
            ST_DONE: done = 1'b1;
            ST_ERR: begin
                illegal = 1'b1;
                pc_inc  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer. Stimulus tasks push the expected
// output vector for each busy cycle (tagged with its cycle number); a monitor
// per DUT pops an entry on every cycle in which that DUT shows any activity.
// Vector layout: {busy, done, illegal, pc_inc, rx_out[5:0], rx_in[5:0],
//                 alu_in0, alu_in1, alu_out_latch, alu_out_en}
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [19:0] v;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // DUT A: default parameters.
    logic        start_a;
    logic [15:0] instr_a;
    logic        busy_a, done_a, ill_a, pc_a, i0_a, i1_a, ol_a, oe_a;
    logic [5:0]  rxo_a, rxi_a;
    logic [19:0] out_a;

    alu_op_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .instruction(instr_a),
        .busy(busy_a), .done(done_a), .illegal(ill_a), .pc_inc(pc_a),
        .rx_out(rxo_a), .rx_in(rxi_a), .alu_in0(i0_a), .alu_in1(i1_a),
        .alu_out_latch(ol_a), .alu_out_en(oe_a)
    );
    assign out_a = {busy_a, done_a, ill_a, pc_a, rxo_a, rxi_a, i0_a, i1_a, ol_a, oe_a};

    // DUT B: longer bus settle, opcode 9 is compare-type.
    logic        start_b;
    logic [15:0] instr_b;
    logic        busy_b, done_b, ill_b, pc_b, i0_b, i1_b, ol_b, oe_b;
    logic [5:0]  rxo_b, rxi_b;
    logic [19:0] out_b;

    alu_op_sequencer #(.WAIT_CYC(3), .NOWB_MASK(16'h0200)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .instruction(instr_b),
        .busy(busy_b), .done(done_b), .illegal(ill_b), .pc_inc(pc_b),
        .rx_out(rxo_b), .rx_in(rxi_b), .alu_in0(i0_b), .alu_in1(i1_b),
        .alu_out_latch(ol_b), .alu_out_en(oe_b)
    );
    assign out_b = {busy_b, done_b, ill_b, pc_b, rxo_b, rxi_b, i0_b, i1_b, ol_b, oe_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [19:0] mk(input logic b, input logic d, input logic il,
                                       input logic pc, input logic [5:0] ro,
                                       input logic [5:0] ri, input logic i0, input logic i1,
                                       input logic ol, input logic oe);
        return {b, d, il, pc, ro, ri, i0, i1, ol, oe};
    endfunction

    function automatic void push_a(input int c, input logic [19:0] v);
        q_a.push_back('{c, v});
    endfunction

    function automatic void push_b(input int c, input logic [19:0] v);
        q_b.push_back('{c, v});
    endfunction

    // Monitors: any active cycle must match the next expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_a !== 20'h0) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_activity", 32'(out_a), 32'h0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_cycle", 32'(cyc), 32'(e.cyc));
                check("a_outputs", 32'(out_a), 32'(e.v));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && out_b !== 20'h0) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_activity", 32'(out_b), 32'h0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_cycle", 32'(cyc), 32'(e.cyc));
                check("b_outputs", 32'(out_b), 32'(e.v));
            end
        end
    end

    task automatic drain_a();
        int n = 0;
        while (q_a.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_drain", 32'(q_a.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_b();
        int n = 0;
        while (q_b.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_drain", 32'(q_b.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Binary op 0x9042: p1=1 (6'b010000), p2=2 (6'b001000), WAIT_CYC=1.
    // Only the first 'upto' cycles are expected (used by the reset case).
    task automatic issue_binary(input int upto);
        int b;
        logic [19:0] tr [1:9];
        @(negedge clk);
        b = cyc;
        start_a = 1'b1;
        instr_a = 16'h9042;
        tr[1] = mk(1, 0, 0, 1, 6'b010000, 6'b0, 0, 0, 0, 0);
        tr[2] = mk(1, 0, 0, 0, 6'b010000, 6'b0, 1, 0, 0, 0);
        tr[3] = mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 0, 0);
        tr[4] = mk(1, 0, 0, 0, 6'b001000, 6'b0, 0, 0, 0, 0);
        tr[5] = mk(1, 0, 0, 0, 6'b001000, 6'b0, 0, 1, 0, 0);
        tr[6] = mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 1, 0);
        tr[7] = mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 0, 1);
        tr[8] = mk(1, 0, 0, 0, 6'b0, 6'b010000, 0, 0, 0, 1);
        tr[9] = mk(1, 1, 0, 0, 6'b0, 6'b0, 0, 0, 0, 0);
        for (int k = 1; k <= upto; k++) push_a(b + k, tr[k]);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        instr_a = 16'h0;
        instr_b = 16'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_a_outputs", 32'(out_a), 32'h0);
        check("reset_b_outputs", 32'(out_b), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: binary op.
        issue_binary(9);
        drain_a();

        // 2: unary op 0xF140, p1=5 (6'b000001).
        begin
            int b;
            @(negedge clk);
            b = cyc;
            start_a = 1'b1;
            instr_a = 16'hF140;
            push_a(b + 1, mk(1, 0, 0, 1, 6'b000001, 6'b0, 0, 0, 0, 0));
            push_a(b + 2, mk(1, 0, 0, 0, 6'b000001, 6'b0, 1, 0, 0, 0));
            push_a(b + 3, mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 1, 0));
            push_a(b + 4, mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 0, 1));
            push_a(b + 5, mk(1, 0, 0, 0, 6'b0, 6'b000001, 0, 0, 0, 1));
            push_a(b + 6, mk(1, 1, 0, 0, 6'b0, 6'b0, 0, 0, 0, 0));
            @(negedge clk);
            start_a = 1'b0;
        end
        drain_a();

        // 3: illegal destination 0xA1C0 (p1=7).
        begin
            int b;
            @(negedge clk);
            b = cyc;
            start_a = 1'b1;
            instr_a = 16'hA1C0;
            push_a(b + 1, mk(1, 0, 1, 1, 6'b0, 6'b0, 0, 0, 0, 0));
            @(negedge clk);
            start_a = 1'b0;
        end
        drain_a();

        // 4: non-ALU opcode 0x3000 held for 20 cycles.
        @(negedge clk);
        start_a = 1'b1;
        instr_a = 16'h3000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("non_alu_idle", 32'(out_a), 32'h0);
        end
        start_a = 1'b0;
        @(negedge clk);

        // 5: reset asserted during B_DRV, then a fresh run.
        issue_binary(4);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_outputs", 32'(out_a), 32'h0);
        check("mid_reset_queue", 32'(q_a.size()), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue_binary(9);
        drain_a();

        // 6: DUT B, start held, instruction changed mid-operation.
        begin
            int b;
            @(negedge clk);
            b = cyc;
            start_b = 1'b1;
            instr_b = 16'h9042;
            push_b(b + 1, mk(1, 0, 0, 1, 6'b010000, 6'b0, 0, 0, 0, 0));
            for (int k = 2; k <= 3; k++) push_b(b + k, mk(1, 0, 0, 0, 6'b010000, 6'b0, 0, 0, 0, 0));
            push_b(b + 4, mk(1, 0, 0, 0, 6'b010000, 6'b0, 1, 0, 0, 0));
            push_b(b + 5, mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 0, 0));
            for (int k = 6; k <= 8; k++) push_b(b + k, mk(1, 0, 0, 0, 6'b001000, 6'b0, 0, 0, 0, 0));
            push_b(b + 9, mk(1, 0, 0, 0, 6'b001000, 6'b0, 0, 1, 0, 0));
            push_b(b + 10, mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 1, 0));
            push_b(b + 11, mk(1, 1, 0, 0, 6'b0, 6'b0, 0, 0, 0, 0));
            // Cycle 12 idle; 0xB000 (op 11, p1=p2=0) accepted at its end.
            push_b(b + 13, mk(1, 0, 0, 1, 6'b100000, 6'b0, 0, 0, 0, 0));
            for (int k = 14; k <= 15; k++) push_b(b + k, mk(1, 0, 0, 0, 6'b100000, 6'b0, 0, 0, 0, 0));
            push_b(b + 16, mk(1, 0, 0, 0, 6'b100000, 6'b0, 1, 0, 0, 0));
            push_b(b + 17, mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 0, 0));
            for (int k = 18; k <= 20; k++) push_b(b + k, mk(1, 0, 0, 0, 6'b100000, 6'b0, 0, 0, 0, 0));
            push_b(b + 21, mk(1, 0, 0, 0, 6'b100000, 6'b0, 0, 1, 0, 0));
            push_b(b + 22, mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 1, 0));
            push_b(b + 23, mk(1, 0, 0, 0, 6'b0, 6'b0, 0, 0, 0, 1));
            push_b(b + 24, mk(1, 0, 0, 0, 6'b0, 6'b100000, 0, 0, 0, 1));
            push_b(b + 25, mk(1, 1, 0, 0, 6'b0, 6'b0, 0, 0, 0, 0));
            repeat (2) @(negedge clk);
            instr_b = 16'hB000;
            repeat (12) @(negedge clk);
            start_b = 1'b0;
        end
        drain_b();
        check("a_quiet_at_end", 32'(out_a), 32'h0);
        check("b_quiet_at_end", 32'(out_b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
